apb_sram_slv: RTL and testbench

APB_SRAM_SLV -- requirements
Module: apb_sram_slv

---
 rtl/apb_pkg.sv | 8 +
 rtl/dp_ram_be.sv | 35 +++
 rtl/apb_sram_slv.sv | 81 ++++++++
 tb/tb_apb_sram_slv.sv | 127 ++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type, counter width and address-check helper for the APB SRAM slave
package apb_pkg;
  typedef enum logic [1:0] {APB_MEM_IDLE, APB_MEM_WAIT, APB_MEM_ACCESS} apb_mem_state_t;
  localparam int WAIT_CNT_W = 4;
  function automatic logic addr_err(input logic [31:0] a, input int bytes, input int depth);
    return ((a & 32'(bytes - 1)) != 32'd0) || ((a >> $clog2(bytes)) >= 32'(depth));
  endfunction
endpackage

// File: rtl/dp_ram_be.sv
// dp_ram_be: byte-enable write/async read port A plus registered read port B, read-before-write
module dp_ram_be #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_we,
  input  logic [DW/8-1:0] a_be,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  output logic [DW-1:0]   a_rdata,
  input  logic            b_en,
  input  logic [AW-1:0]   b_addr,
  output logic [DW-1:0]   b_rdata,
  output logic            b_err
);
  logic [DW-1:0] mem [DEPTH];
  logic          b_oor;
  assign a_rdata = mem[a_addr];
  assign b_oor   = 32'(b_addr) >= 32'(DEPTH);
  always_ff @(posedge clk)
    for (int i = 0; i < DW/8; i++)
      if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
  // nonblocking read of mem gives old data when port A writes the same word
  always_ff @(posedge clk)
    if (rst) begin
      b_rdata <= '0;
      b_err   <= 1'b0;
    end else if (b_en) begin
      b_rdata <= b_oor ? '0 : mem[b_addr];
      b_err   <= b_oor;
    end
endmodule

// File: rtl/apb_sram_slv.sv
// apb_sram_slv: APB slave onto byte-enable SRAM with fixed wait states and a read-only side port
module apb_sram_slv import apb_pkg::*; #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_WIDTH-1:0]        PADDR,
  input  logic [DATA_WIDTH-1:0]        PWDATA,
  input  logic [DATA_WIDTH/8-1:0]      PSTRB,
  output logic [DATA_WIDTH-1:0]        PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic                         B_EN,
  input  logic [$clog2(MEM_DEPTH)-1:0] B_ADDR,
  output logic [DATA_WIDTH-1:0]        B_RDATA,
  output logic                         B_ERR
);
  localparam int NB = DATA_WIDTH/8;
  localparam int LB = $clog2(NB);
  localparam int MW = $clog2(MEM_DEPTH);
  apb_mem_state_t st, nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_in;
  logic [DATA_WIDTH-1:0] wdata_q, a_rdata, rd_val;
  logic [NB-1:0]         strb_q;
  logic                  wr_q, wr_in, setup, err_q, err_in, we;
  logic [MW-1:0]         a_addr;
  assign setup   = st == APB_MEM_IDLE && PSEL && !PENABLE;
  // with no wait states ACCESS is entered at the setup edge, before addr_q is loaded
  assign addr_in = st == APB_MEM_IDLE ? PADDR : addr_q;
  assign wr_in   = st == APB_MEM_IDLE ? PWRITE : wr_q;
  assign err_in  = addr_err(32'(addr_in), NB, MEM_DEPTH);
  assign err_q   = addr_err(32'(addr_q), NB, MEM_DEPTH);
  assign a_addr  = MW'(32'(addr_in) >> LB);
  assign rd_val  = (!wr_in && !err_in) ? a_rdata : '0;
  assign we      = st == APB_MEM_ACCESS && PSEL && PENABLE && wr_q && !err_q && !PRESET;
  always_ff @(posedge PCLK)
    if (PRESET) st <= APB_MEM_IDLE;
    else        st <= nxt;
  always_comb begin
    nxt = st;
    unique case (st)
      APB_MEM_IDLE:   nxt = setup ? (WAIT_STATES > 0 ? APB_MEM_WAIT : APB_MEM_ACCESS) : APB_MEM_IDLE;
      APB_MEM_WAIT:   nxt = !PSEL ? APB_MEM_IDLE : (cnt == '0 ? APB_MEM_ACCESS : APB_MEM_WAIT);
      APB_MEM_ACCESS: nxt = (!PSEL || PENABLE) ? APB_MEM_IDLE : APB_MEM_ACCESS;
      default:        nxt = APB_MEM_IDLE;
    endcase
  end
  always_comb begin
    PREADY  = st == APB_MEM_ACCESS;
    PSLVERR = st == APB_MEM_ACCESS && err_q;
  end
  always_ff @(posedge PCLK)
    if (setup) begin
      addr_q  <= PADDR;
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  // read data is captured on entry to ACCESS, the write commits on the completing edge
  always_ff @(posedge PCLK)
    if (PRESET) begin
      cnt    <= '0;
      PRDATA <= '0;
    end else begin
      if (setup)                                cnt <= WAIT_CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
      else if (st == APB_MEM_WAIT && cnt != '0) cnt <= cnt - 1'b1;
      PRDATA <= nxt != APB_MEM_ACCESS ? '0 : (st != APB_MEM_ACCESS ? rd_val : PRDATA);
    end
  dp_ram_be #(.DW(DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_ram (
    .clk(PCLK), .rst(PRESET),
    .a_we(we), .a_be(strb_q), .a_addr(a_addr), .a_wdata(wdata_q), .a_rdata(a_rdata),
    .b_en(B_EN), .b_addr(B_ADDR), .b_rdata(B_RDATA), .b_err(B_ERR)
  );
endmodule

// File: tb/tb_apb_sram_slv.sv
// tb_apb_sram_slv: scoreboard bench driving a zero-wait and a three-wait-state slave
module tb_apb_sram_slv;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, psel0, psel3, penable, pwrite, b_en;
  logic [12:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [9:0]  b_addr;
  logic [31:0] prdata0, prdata3, b_rdata0, b_rdata3;
  logic        pready0, pready3, pslverr0, pslverr3, b_err0, b_err3;
  apb_sram_slv #(.ADDR_WIDTH(13)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .B_EN(b_en), .B_ADDR(b_addr), .B_RDATA(b_rdata0), .B_ERR(b_err0));
  apb_sram_slv #(.ADDR_WIDTH(12), .MEM_DEPTH(1000), .WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr[11:0]), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .B_EN(b_en), .B_ADDR(b_addr), .B_RDATA(b_rdata3), .B_ERR(b_err3));

  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int d, input logic wr, input logic [12:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] erd, input logic eerr, input bit side);
    exp_t e;
    int n;
    logic rdy;
    e.rdata = erd; e.err = eerr; e.lat = d == 0 ? 1 : 4;
    sb.push_back(e);
    @(negedge clk);
    psel0 = d == 0; psel3 = d == 3; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    n = 1;
    rdy = d == 0 ? pready0 : pready3;
    penable = 1'b1;
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
      rdy = d == 0 ? pready0 : pready3;
    end
    e = sb.pop_front();
    chk($sformatf("lat@%0h", a), 64'(n), 64'(e.lat));
    chk($sformatf("prdata@%0h", a), d == 0 ? prdata0 : prdata3, e.rdata);
    chk($sformatf("pslverr@%0h", a), d == 0 ? pslverr0 : pslverr3, e.err);
    if (side) begin b_en = 1'b1; b_addr = 10'd16; end
    @(negedge clk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    chk("prdata_idle", d == 0 ? prdata0 : prdata3, 0);
  endtask

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; b_en = 1'b0; b_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_pready0", pready0, 0);
    chk("rst_pslverr0", pslverr0, 0);
    chk("rst_prdata0", prdata0, 0);
    chk("rst_b_rdata0", b_rdata0, 0);
    chk("rst_b_err0", b_err0, 0);
    chk("rst_pready3", pready3, 0);
    rst = 1'b0;
    xfer(0, 1, 13'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    xfer(0, 0, 13'h010, 0, 4'h0, 32'hDEADBEEF, 0, 0);
    xfer(0, 1, 13'h020, 32'h11223344, 4'hF, 0, 0, 0);
    xfer(0, 1, 13'h020, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    xfer(0, 0, 13'h020, 0, 4'hF, 32'h11BB33DD, 0, 0);
    xfer(0, 1, 13'h020, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    xfer(0, 0, 13'h020, 0, 4'h0, 32'h11BB33DD, 0, 0);
    xfer(0, 1, 13'h004, 32'h12345678, 4'hF, 0, 0, 0);
    xfer(0, 0, 13'h1000, 0, 4'h0, 0, 1, 0);
    xfer(0, 1, 13'h006, 32'hFFFFFFFF, 4'hF, 0, 1, 0);
    xfer(0, 0, 13'h004, 0, 4'h0, 32'h12345678, 0, 0);
    xfer(0, 1, 13'h0FFC, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    xfer(0, 0, 13'h0FFC, 0, 4'h0, 32'hCAFEF00D, 0, 0);
    xfer(0, 1, 13'h040, 32'd5, 4'hF, 0, 0, 0);
    xfer(0, 1, 13'h040, 32'd9, 4'hF, 0, 0, 1);
    chk("b_rbw_old", b_rdata0, 5);
    chk("b_err_ok", b_err0, 0);
    @(negedge clk);
    chk("b_new", b_rdata0, 9);
    b_en = 1'b0; b_addr = 10'd4;
    @(negedge clk);
    chk("b_hold", b_rdata0, 9);
    // setup then drop PSEL in ACCESS: the write must not land
    @(negedge clk);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h040; pwdata = 32'h77; pstrb = 4'hF;
    @(negedge clk);
    psel0 = 1'b0;
    xfer(0, 0, 13'h040, 0, 4'h0, 32'd9, 0, 0);
    xfer(3, 1, 13'h000, 32'h0BADCAFE, 4'hF, 0, 0, 0);
    xfer(3, 0, 13'h000, 0, 4'h0, 32'h0BADCAFE, 0, 0);
    xfer(3, 0, 13'h0FA0, 0, 4'h0, 0, 1, 0);
    xfer(3, 1, 13'h0F9C, 32'h55AA55AA, 4'hF, 0, 0, 0);
    xfer(3, 0, 13'h0F9C, 0, 4'h0, 32'h55AA55AA, 0, 0);
    b_en = 1'b1; b_addr = 10'd1000;
    @(negedge clk);
    chk("b_oor_err", b_err3, 1);
    chk("b_oor_data", b_rdata3, 0);
    b_en = 1'b0;
    // reset in the middle of the WAIT phase of a write
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h000; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_pready", pready3, 0);
    chk("wrst_pslverr", pslverr3, 0);
    chk("wrst_prdata", prdata3, 0);
    chk("wrst_b_err", b_err3, 0);
    rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
    xfer(3, 0, 13'h000, 0, 4'h0, 32'h0BADCAFE, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
